// File: rtl/mdio_controller.sv
// mdio_controller: clause-22 MDIO station manager; serializes host frames and captures read data
module mdio_controller #(
    parameter int MDC_HALF = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MDIO_START,
    input  logic [31:0] T_DATA,
    input  logic        MDIO_IN,
    output logic        MDC,
    output logic        MDIO_OE,
    output logic        MDIO_OUT,
    output logic [15:0] RD_DATA,
    output logic        DATA_RDY,
    output logic        BUSY
);
    typedef enum logic [1:0] {IDLE, ALIGN, SHIFT, DONE} state_t;
    localparam logic [7:0] DIV_TOP = 8'(MDC_HALF - 1);
    state_t      state, state_nxt;
    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt, bit_cnt_nxt;
    logic [31:0] shreg, shreg_nxt;
    logic [14:0] rx_sh, rx_sh_nxt;
    logic [15:0] rd_data_nxt;
    logic        is_rd, is_rd_nxt, oe_nxt, out_nxt, rdy_nxt, busy_nxt;
    logic        div_end, fall;

    assign div_end = div_cnt == DIV_TOP;
    assign fall    = div_end && MDC;

    // free-running MDC divider; MDC toggles each time the count wraps
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            div_cnt <= '0;
            MDC     <= 1'b0;
        end else begin
            div_cnt <= div_end ? '0 : div_cnt + 8'd1;
            MDC     <= MDC ^ div_end;
        end
    end

    // FSM state and registered frame/output datapath
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state    <= IDLE;
            bit_cnt  <= 5'd31;
            shreg    <= '0;
            rx_sh    <= '0;
            is_rd    <= 1'b0;
            MDIO_OE  <= 1'b0;
            MDIO_OUT <= 1'b0;
            RD_DATA  <= '0;
            DATA_RDY <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            rx_sh    <= rx_sh_nxt;
            is_rd    <= is_rd_nxt;
            MDIO_OE  <= oe_nxt;
            MDIO_OUT <= out_nxt;
            RD_DATA  <= rd_data_nxt;
            DATA_RDY <= rdy_nxt;
            BUSY     <= busy_nxt;
        end
    end

    // next state and outputs; bits move only on MDC fall edges so each is stable across a rise
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        rx_sh_nxt   = rx_sh;
        is_rd_nxt   = is_rd;
        oe_nxt      = MDIO_OE;
        out_nxt     = MDIO_OUT;
        rd_data_nxt = RD_DATA;
        rdy_nxt     = 1'b0;
        busy_nxt    = BUSY;
        case (state)
            IDLE: if (MDIO_START) begin
                shreg_nxt = T_DATA;
                is_rd_nxt = T_DATA[29];
                busy_nxt  = 1'b1;
                state_nxt = ALIGN;
            end
            ALIGN: if (fall) begin
                oe_nxt      = 1'b1;
                out_nxt     = shreg[31];
                bit_cnt_nxt = 5'd31;
                state_nxt   = SHIFT;
            end
            SHIFT: if (fall) begin
                if (bit_cnt <= 5'd15) rx_sh_nxt = {rx_sh[13:0], MDIO_IN};
                if (bit_cnt == 5'd0) begin
                    state_nxt = DONE;
                    oe_nxt    = 1'b0;
                    out_nxt   = 1'b0;
                    busy_nxt  = 1'b0;
                    if (is_rd) begin
                        rd_data_nxt = {rx_sh, MDIO_IN};
                        rdy_nxt     = 1'b1;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt - 5'd1;
                    shreg_nxt   = shreg << 1;
                    oe_nxt      = !is_rd || bit_cnt > 5'd18;
                    out_nxt     = oe_nxt && shreg[30];
                end
            end
            DONE: begin
                bit_cnt_nxt = 5'd31;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mdio_controller.sv
// tb_mdio_controller: edge-count reference model for two MDC_HALF settings plus directed frame checks
module tb_mdio_controller;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        start [2];
    logic [31:0] tdata [2];
    logic [15:0] resp [2];
    logic        mdio_in [2];
    logic        mdc [2], oe [2], mout [2], rdy [2], busy [2];
    logic [15:0] rdd [2];
    logic [31:0] cap [2];
    int          noe [2], rdy_cnt [2], busy_len [2], nfr [2];
    int          cmp = 0, mism = 0;

    always #5 CLK = ~CLK;

    mdio_controller #(.MDC_HALF(2)) u0 (
        .CLK(CLK), .RESET(RESET), .MDIO_START(start[0]), .T_DATA(tdata[0]), .MDIO_IN(mdio_in[0]),
        .MDC(mdc[0]), .MDIO_OE(oe[0]), .MDIO_OUT(mout[0]), .RD_DATA(rdd[0]), .DATA_RDY(rdy[0]), .BUSY(busy[0])
    );

    mdio_controller #(.MDC_HALF(1)) u1 (
        .CLK(CLK), .RESET(RESET), .MDIO_START(start[1]), .T_DATA(tdata[1]), .MDIO_IN(mdio_in[1]),
        .MDC(mdc[1]), .MDIO_OE(oe[1]), .MDIO_OUT(mout[1]), .RD_DATA(rdd[1]), .DATA_RDY(rdy[1]), .BUSY(busy[1])
    );

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            mism++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : m
        localparam int H = (g == 0) ? 2 : 1;
        int          k = 0, f0 = 0, done_at = 0, next_ok = 0, idx = -1;
        bit          active = 1'b0, rd = 1'b0, valid = 1'b0;
        logic [31:0] frame = '0;
        logic [15:0] mresp = '0, e_rd = '0;
        logic        e_mdc = 1'b0, e_oe = 1'b0, e_out = 1'b0, e_busy = 1'b0, e_rdy = 1'b0;
        logic        pm = 1'b0, pb = 1'b0;

        // reference: outputs as a function of edges since reset and the accepted frame's timeline
        always @(posedge CLK) begin
            if (!RESET) begin
                k = 0; active = 1'b0; next_ok = 0; idx = -1; valid = 1'b1;
                e_mdc = 1'b0; e_oe = 1'b0; e_out = 1'b0; e_busy = 1'b0; e_rdy = 1'b0; e_rd = '0;
            end else begin
                k++;
                if (!active && k >= next_ok && start[g]) begin
                    active = 1'b1; frame = tdata[g]; rd = tdata[g][29]; mresp = resp[g];
                    f0 = (k / (2 * H) + 1) * (2 * H);
                    done_at = f0 + 64 * H;
                    next_ok = done_at + 2;
                end
                e_mdc = 1'((k / H) % 2);
                e_oe = 1'b0; e_out = 1'b0; e_busy = 1'b0; e_rdy = 1'b0; idx = -1;
                if (active && k < done_at) begin
                    e_busy = 1'b1;
                    if (k >= f0) begin
                        idx = 31 - (k - f0) / (2 * H);
                        e_oe = !rd || idx >= 18;
                        e_out = e_oe && frame[idx[4:0]];
                    end
                end else if (active) begin
                    active = 1'b0;
                    if (rd) begin e_rd = mresp; e_rdy = 1'b1; end
                end
            end
        end

        // per-cycle comparison, then the PHY presents the next response bit
        always @(negedge CLK) begin
            if (valid) begin
                check("MDC", g, 32'(mdc[g]), 32'(e_mdc));
                check("MDIO_OE", g, 32'(oe[g]), 32'(e_oe));
                check("MDIO_OUT", g, 32'(mout[g]), 32'(e_out));
                check("BUSY", g, 32'(busy[g]), 32'(e_busy));
                check("DATA_RDY", g, 32'(rdy[g]), 32'(e_rdy));
                check("RD_DATA", g, 32'(rdd[g]), 32'(e_rd));
            end
            mdio_in[g] = (active && rd && idx >= 0 && idx <= 15) ? mresp[idx[3:0]] : 1'($urandom);
        end

        // peripheral-side observer: samples driven bits on MDC rise, per-frame statistics
        always @(negedge CLK) begin
            if (busy[g] === 1'b1 && !pb) begin
                cap[g] = '0; noe[g] = 0; rdy_cnt[g] = 0; busy_len[g] = 0; nfr[g]++;
            end
            if (busy[g] === 1'b1) busy_len[g]++;
            if (mdc[g] === 1'b1 && !pm && oe[g] === 1'b1) begin
                cap[g] = {cap[g][30:0], mout[g]};
                noe[g]++;
            end
            if (rdy[g] === 1'b1) begin
                rdy_cnt[g]++;
                check("RDY_AT_BUSY_FALL", g, 32'({pb, busy[g]}), 32'd2);
            end
            pm = mdc[g] === 1'b1;
            pb = busy[g] === 1'b1;
        end
    end

    task automatic wait_idle(input int d);
        int n = 0;
        while (busy[d] !== 1'b0 && n < 400) begin
            @(negedge CLK);
            n++;
        end
        check("WAIT_IDLE", d, 32'(busy[d]), 32'd0);
    endtask

    task automatic send(input int d, input logic [31:0] td, input logic [15:0] r);
        @(negedge CLK);
        tdata[d] = td; resp[d] = r; start[d] = 1'b1;
        @(negedge CLK);
        start[d] = 1'b0;
        wait_idle(d);
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        int fr, frames, low, n;
        logic pbusy;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; tdata[d] = '0; resp[d] = '0; cap[d] = '0;
            noe[d] = 0; rdy_cnt[d] = 0; busy_len[d] = 0; nfr[d] = 0;
        end
        repeat (3) @(negedge CLK);
        check("RST_BUSY", 0, 32'(busy[0]), 32'd0);
        check("RST_RD", 0, 32'(rdd[0]), 32'd0);
        check("RST_MDC", 1, 32'(mdc[1]), 32'd0);
        RESET = 1'b1;

        send(0, 32'h508EABCD, 16'h0000);
        check("WR_FRAME", 0, cap[0], 32'h508EABCD);
        check("WR_OE_BITS", 0, 32'(noe[0]), 32'd32);
        check("WR_DATA", 0, 32'(cap[0][15:0]), 32'hABCD);
        check("WR_ADDR", 0, 32'(cap[0][22:18]), 32'd3);
        check("WR_NO_RDY", 0, 32'(rdy_cnt[0]), 32'd0);
        check("WR_BUSY_LEN", 0, 32'(busy_len[0] >= 129 && busy_len[0] <= 132), 32'd1);
        check("WR_RD_KEPT", 0, 32'(rdd[0]), 32'd0);

        send(0, 32'h608C0000, 16'h1234);
        check("RD_OE_BITS", 0, 32'(noe[0]), 32'd14);
        check("RD_HDR", 0, 32'(cap[0][13:0]), 32'h1823);
        check("RD_DATA_LIT", 0, 32'(rdd[0]), 32'h1234);
        check("RD_RDY_ONCE", 0, 32'(rdy_cnt[0]), 32'd1);

        fr = nfr[0];
        @(negedge CLK);
        tdata[0] = 32'h608C0000; resp[0] = 16'hBEEF; start[0] = 1'b1;
        @(negedge CLK);
        start[0] = 1'b0;
        repeat (19) @(negedge CLK);
        tdata[0] = 32'h508E5555; resp[0] = 16'h0F0F; start[0] = 1'b1;
        @(negedge CLK);
        start[0] = 1'b0; tdata[0] = $urandom;
        wait_idle(0);
        repeat (3) @(negedge CLK);
        check("IGN_FRAMES", 0, 32'(nfr[0] - fr), 32'd1);
        check("IGN_RD", 0, 32'(rdd[0]), 32'hBEEF);
        check("IGN_RDY", 0, 32'(rdy_cnt[0]), 32'd1);
        check("IGN_OE_BITS", 0, 32'(noe[0]), 32'd14);

        @(negedge CLK);
        tdata[0] = 32'h608C0000; resp[0] = 16'h5A5A; start[0] = 1'b1;
        @(negedge CLK);
        start[0] = 1'b0;
        n = 0;
        while (noe[0] < 10 && n < 300) begin @(negedge CLK); n++; end
        check("RST_WAIT10", 0, 32'(noe[0] >= 10), 32'd1);
        RESET = 1'b0;
        @(negedge CLK);
        check("RST_MID_MDC", 0, 32'(mdc[0]), 32'd0);
        check("RST_MID_OE", 0, 32'(oe[0]), 32'd0);
        check("RST_MID_BUSY", 0, 32'(busy[0]), 32'd0);
        check("RST_MID_RD", 0, 32'(rdd[0]), 32'd0);
        check("RST_MID_RDY", 0, 32'(rdy[0]), 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        send(0, 32'h608C0000, 16'hA5C3);
        check("POST_RST_RD", 0, 32'(rdd[0]), 32'hA5C3);
        check("POST_RST_RDY", 0, 32'(rdy_cnt[0]), 32'd1);

        frames = 0; low = 0; pbusy = 1'b0;
        tdata[1] = {4'b0101, 28'($urandom)}; resp[1] = $urandom; start[1] = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge CLK);
            if (busy[1] && !pbusy) begin
                frames++;
                if (frames > 1) check("B2B_GAP", 1, 32'(low), 32'd2);
                tdata[1] = (frames % 2 == 1) ? {4'b0110, 28'($urandom)} : {4'b0101, 28'($urandom)};
                resp[1] = $urandom;
                low = 0;
            end
            if (!busy[1]) low++;
            pbusy = busy[1];
        end
        start[1] = 1'b0;
        check("B2B_FRAMES", 1, 32'(frames >= 6), 32'd1);
        wait_idle(1);

        for (int c = 0; c < 4000; c++) begin
            @(negedge CLK);
            if (c == 2000) RESET = 1'b0;
            if (c == 2002) RESET = 1'b1;
            for (int d = 0; d < 2; d++) begin
                start[d] = ($urandom % 8) == 0;
                tdata[d] = $urandom;
                resp[d] = $urandom;
            end
        end
        start[0] = 1'b0; start[1] = 1'b0;
        wait_idle(0);
        wait_idle(1);
        repeat (4) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end
endmodule
